// File: rtl/edge_event_arbiter_pkg.sv
// Shared constants for the edge event arbiter: default channel count and
// the encoding of the event_kind bit.
package edge_event_arbiter_pkg;

  localparam int NCH_DEFAULT = 4;

  localparam logic KIND_RISE = 1'b1;
  localparam logic KIND_FALL = 1'b0;

  // Index width for a channel count, never narrower than one bit.
  function automatic int id_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Edge inputs, event handshake and overflow flags of the edge event arbiter.
// The master side is the arbiter; the slave side is conditioners plus consumer.
interface edge_event_arbiter_if
  import edge_event_arbiter_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT
);

  localparam int IDW = id_width(NCH);

  logic [NCH-1:0] positiveedge;
  logic [NCH-1:0] negativeedge;
  logic [NCH-1:0] conditioned;
  logic           event_ready;
  logic           clear_overflow;
  logic           event_valid;
  logic [IDW-1:0] event_id;
  logic           event_kind;
  logic [NCH-1:0] overflow;

  modport master (
    input  positiveedge, negativeedge, conditioned, event_ready, clear_overflow,
    output event_valid, event_id, event_kind, overflow
  );

  modport slave (
    output positiveedge, negativeedge, conditioned, event_ready, clear_overflow,
    input  event_valid, event_id, event_kind, overflow
  );

endinterface

// File: rtl/edge_pending_slot.sv
// One channel's rise/fall pending bits and its sticky overflow flag.
// An edge that lands on a pending bit being consumed this cycle is kept, not dropped.
module edge_pending_slot (
  input  logic clk,
  input  logic reset,
  input  logic rise_in,
  input  logic fall_in,
  input  logic clr_rise,
  input  logic clr_fall,
  input  logic clear_overflow,
  output logic rise_pend,
  output logic fall_pend,
  output logic overflow
);

  logic rise_keep;
  logic fall_keep;
  logic drop;

  assign rise_keep = rise_pend & ~clr_rise;
  assign fall_keep = fall_pend & ~clr_fall;
  assign drop      = (rise_in & rise_keep) | (fall_in & fall_keep);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of process order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_pend <= 1'b0;
      fall_pend <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rise_pend <= rise_in | rise_keep;
      fall_pend <= fall_in | fall_keep;
      // A fresh drop beats a coincident clear.
      overflow  <= drop | (overflow & ~clear_overflow);
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Collects per-channel edge events and presents them one at a time through a
// single valid/ready output register, picking channels round-robin.
module edge_event_arbiter
  import edge_event_arbiter_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  edge_event_arbiter_if.master  bus
);

  localparam int IDW = id_width(NCH);

  logic [NCH-1:0] rise_pend;
  logic [NCH-1:0] fall_pend;
  logic [NCH-1:0] clr_rise;
  logic [NCH-1:0] clr_fall;
  logic [NCH-1:0] any_pend;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] rr_next;
  logic           win_found;
  logic           win_kind;
  logic           out_free;
  logic           load;

  for (genvar i = 0; i < NCH; i++) begin : g_slot
    edge_pending_slot u_slot (
      .clk           (clk),
      .reset         (reset),
      .rise_in       (bus.positiveedge[i]),
      .fall_in       (bus.negativeedge[i]),
      .clr_rise      (clr_rise[i]),
      .clr_fall      (clr_fall[i]),
      .clear_overflow(bus.clear_overflow),
      .rise_pend     (rise_pend[i]),
      .fall_pend     (fall_pend[i]),
      .overflow      (bus.overflow[i])
    );
  end

  assign any_pend = rise_pend | fall_pend;
  assign out_free = ~bus.event_valid | bus.event_ready;
  assign load     = out_free & win_found;

  // Round-robin search starting at rr_ptr, wrapping at NCH (need not be a power of two).
  always_comb begin
    logic [IDW:0] pos;
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    pos       = '0;
    for (int k = 0; k < NCH; k++) begin
      pos = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(NCH)) pos = pos - (IDW+1)'(NCH);
      if (!win_found && any_pend[pos[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = pos[IDW-1:0];
      end
    end
  end

  // With both edges pending, the debounced level tells which came first:
  // a high level means the rise already happened, so the fall is older.
  always_comb begin
    win_kind = KIND_FALL;
    if (rise_pend[win_idx] && fall_pend[win_idx])
      win_kind = bus.conditioned[win_idx] ? KIND_FALL : KIND_RISE;
    else if (rise_pend[win_idx])
      win_kind = KIND_RISE;
  end

  always_comb begin
    clr_rise = '0;
    clr_fall = '0;
    if (load) begin
      if (win_kind == KIND_RISE) clr_rise[win_idx] = 1'b1;
      else                       clr_fall[win_idx] = 1'b1;
    end
  end

  assign rr_next = (win_idx == IDW'(NCH-1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.event_valid <= 1'b0;
      bus.event_id    <= '0;
      bus.event_kind  <= KIND_FALL;
      rr_ptr          <= '0;
    end else if (out_free) begin
      bus.event_valid <= win_found;
      if (win_found) begin
        bus.event_id   <= win_idx;
        bus.event_kind <= win_kind;
        rr_ptr         <= rr_next;
      end
    end
  end

endmodule
